// File: rtl/bus_ctrl_pkg.sv
// bus_ctrl_pkg: shared FSM state type, access-width encodings and store-lane helpers
// for the data bus controller.
package bus_ctrl_pkg;

    // Access width encodings from the control unit; 2'b11 decodes as a word.
    localparam logic [1:0] MEM_WORD = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_BYTE = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StResp
    } bus_state_e;

    // Natural alignment check: bytes are always aligned.
    function automatic logic addr_aligned(logic [1:0] width, logic [1:0] offset);
        case (width)
            MEM_HALF: return ~offset[0];
            MEM_BYTE: return 1'b1;
            default:  return (offset == 2'b00);
        endcase
    endfunction

    // Byte enables for the addressed lanes (loads use the same lanes).
    function automatic logic [3:0] lane_be(logic [1:0] width, logic [1:0] offset);
        case (width)
            MEM_HALF: return offset[1] ? 4'b1100 : 4'b0011;
            MEM_BYTE: return 4'b0001 << offset;
            default:  return 4'b1111;
        endcase
    endfunction

    // Store data replicated across all lanes so the slave can pick any enabled lane.
    function automatic logic [31:0] lane_wdata(logic [1:0] width, logic [31:0] data);
        case (width)
            MEM_HALF: return {2{data[15:0]}};
            MEM_BYTE: return {4{data[7:0]}};
            default:  return data;
        endcase
    endfunction

endpackage

// File: rtl/load_aligner.sv
// load_aligner: picks the addressed byte/half lane of a bus word and zero- or
// sign-extends it to 32 bits. Purely combinational.
module load_aligner
    import bus_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  width,
    input  logic        sign_ext,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection by address offset.
    always_comb begin
        byte_sel = word[7:0];
        unique case (offset)
            2'b00: byte_sel = word[7:0];
            2'b01: byte_sel = word[15:8];
            2'b10: byte_sel = word[23:16];
            2'b11: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = offset[1] ? word[31:16] : word[15:0];
    end

    // Extension to 32 bits according to access width and signedness.
    always_comb begin
        data = word;
        unique case (width)
            MEM_HALF: data = {{16{sign_ext & half_sel[15]}}, half_sel};
            MEM_BYTE: data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            default:  data = word;
        endcase
    end

endmodule

// File: rtl/data_bus_controller.sv
// data_bus_controller: single-outstanding load/store master between the pipeline and a
// req/ack data bus. States IDLE -> REQ -> RESP; misaligned or conflicting requests skip
// the bus and complete with a fault.
// Optional feature: define BUS_TIMEOUT_EN to abort a REQ that sees no ack within
// TIMEOUT_CYCLES cycles (completes with fault and rdata = 0).
module data_bus_controller
    import bus_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_bus_read,
    input  logic        cs_bus_write,
    input  logic [1:0]  cs_mem_width,
    input  logic        cs_load_signed,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    bus_state_e state_q, state_d;

    logic        any_req;
    logic        start_ok;
    logic        start_err;
    logic        tmo_expire;
    logic [31:0] load_result;

    logic        bus_we_q;
    logic [31:0] bus_addr_q;
    logic [31:0] bus_wdata_q;
    logic [3:0]  bus_be_q;
    logic [1:0]  ld_width_q;
    logic [1:0]  ld_off_q;
    logic        ld_signed_q;
    logic [31:0] rdata_q;
    logic        fault_q;

    // Request decode: exactly one of read/write plus natural alignment goes to the bus;
    // anything else that asks for an access completes locally with a fault.
    always_comb begin
        any_req   = cs_bus_read | cs_bus_write;
        start_ok  = (cs_bus_read ^ cs_bus_write) & addr_aligned(cs_mem_width, addr[1:0]);
        start_err = any_req & ~start_ok;
    end

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CntW-1:0] tmo_cnt_q;

    // Counts REQ cycles; restarts whenever the FSM is outside REQ.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_q <= '0;
        end else if (state_q == StReq) begin
            tmo_cnt_q <= tmo_cnt_q + CntW'(1);
        end else begin
            tmo_cnt_q <= '0;
        end
    end

    // Abort in the last allowed REQ cycle unless the ack arrives in that same cycle.
    always_comb begin
        tmo_expire = (state_q == StReq) && !bus_ack &&
                     (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
    end
`else
    logic unused_timeout;

    // Without the timeout the REQ state waits for ack indefinitely.
    always_comb begin
        tmo_expire     = 1'b0;
        unused_timeout = ^TIMEOUT_CYCLES;
    end
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    state_d = StReq;
                end else if (start_err) begin
                    state_d = StResp;
                end
            end
            StReq: begin
                if (bus_ack || tmo_expire) begin
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Bus-side and load-result registers; bus fields are launched once in IDLE and held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
            ld_width_q  <= MEM_WORD;
            ld_off_q    <= 2'b00;
            ld_signed_q <= 1'b0;
            rdata_q     <= '0;
            fault_q     <= 1'b0;
        end else if (state_q == StIdle) begin
            if (start_ok) begin
                bus_we_q    <= cs_bus_write;
                bus_addr_q  <= {addr[31:2], 2'b00};
                bus_wdata_q <= lane_wdata(cs_mem_width, wdata);
                bus_be_q    <= lane_be(cs_mem_width, addr[1:0]);
                ld_width_q  <= cs_mem_width;
                ld_off_q    <= addr[1:0];
                ld_signed_q <= cs_load_signed;
                fault_q     <= 1'b0;
            end else if (start_err) begin
                rdata_q <= '0;
                fault_q <= 1'b1;
            end
        end else if (state_q == StReq) begin
            if (bus_ack) begin
                // Stores leave the previous load result visible.
                if (!bus_we_q) begin
                    rdata_q <= load_result;
                end
            end else if (tmo_expire) begin
                rdata_q <= '0;
                fault_q <= 1'b1;
            end
        end
    end

    load_aligner u_load_aligner (
        .word     (bus_rdata),
        .offset   (ld_off_q),
        .width    (ld_width_q),
        .sign_ext (ld_signed_q),
        .data     (load_result)
    );

    // Outputs: stall covers the request cycle in IDLE and every REQ cycle.
    always_comb begin
        bus_req   = (state_q == StReq);
        stall     = ((state_q == StIdle) && any_req) || (state_q == StReq);
        done      = (state_q == StResp);
        fault     = (state_q == StResp) && fault_q;
        bus_we    = bus_we_q;
        bus_addr  = bus_addr_q;
        bus_wdata = bus_wdata_q;
        bus_be    = bus_be_q;
        rdata     = rdata_q;
    end

endmodule

// File: tb/tb_data_bus_controller.sv
// tb_data_bus_controller: directed and random load/store traffic; expectations are
// queued by the driver and checked by independent bus and completion monitors.
module tb_data_bus_controller;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          stall;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } bus_t;

    logic        clk;
    logic        reset;
    logic        cs_bus_read;
    logic        cs_bus_write;
    logic [1:0]  cs_mem_width;
    logic        cs_load_signed;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        done;
    logic        fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];
    bus_t bus_q[$];
    logic [31:0] last_rdata = 32'h0;

    data_bus_controller #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cs_bus_read    (cs_bus_read),
        .cs_bus_write   (cs_bus_write),
        .cs_mem_width   (cs_mem_width),
        .cs_load_signed (cs_load_signed),
        .addr           (addr),
        .wdata          (wdata),
        .rdata          (rdata),
        .stall          (stall),
        .done           (done),
        .fault          (fault),
        .bus_req        (bus_req),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_be         (bus_be),
        .bus_rdata      (bus_rdata),
        .bus_ack        (bus_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: an access is a window of nb bytes at byte offset off of the word.
    task automatic access(input bit rd, input bit wr, input logic [1:0] w, input bit sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] word, input int delay);
        int          nb;
        int          off;
        bit          ok;
        logic [31:0] mask;
        logic [31:0] val;
        logic [31:0] rep;
        exp_t        e;
        bus_t        b;
        nb   = (w == 2'b01) ? 2 : (w == 2'b10) ? 1 : 4;
        off  = int'(a[1:0]);
        ok   = (rd != wr) && (off % nb == 0);
        mask = (nb == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nb)) - 32'd1;
        if (ok) begin
            rep = 32'h0;
            for (int i = 0; i < 4 / nb; i++) rep = rep | ((wd & mask) << (8 * nb * i));
            b.we    = wr;
            b.addr  = a & ~32'd3;
            b.wdata = rep;
            b.be    = 4'(((1 << nb) - 1) << off);
            bus_q.push_back(b);
            if (rd) begin
                val = (word >> (8 * off)) & mask;
                if (sg && nb < 4 && val[8 * nb - 1]) val = val | ~mask;
                last_rdata = val;
            end
            e.rdata = last_rdata;
            e.fault = 1'b0;
            e.stall = delay + 2;
        end else begin
            last_rdata = 32'h0;
            e.rdata    = 32'h0;
            e.fault    = 1'b1;
            e.stall    = -1;
        end
        exp_q.push_back(e);

        cs_bus_read    = rd;
        cs_bus_write   = wr;
        cs_mem_width   = w;
        cs_load_signed = sg;
        addr           = a;
        wdata          = wd;
        @(posedge clk); #1;
        cs_bus_read  = 1'b0;
        cs_bus_write = 1'b0;
        if (ok) begin
            for (int i = 0; i < delay; i++) begin
                bus_ack   = 1'b0;
                bus_rdata = $urandom;
                @(posedge clk); #1;
            end
            bus_ack   = 1'b1;
            bus_rdata = word;
            @(posedge clk); #1;
        end
        // RESP cycle: requests and acks seen here must be ignored.
        bus_ack      = 1'($urandom_range(0, 1));
        bus_rdata    = $urandom;
        cs_bus_read  = 1'($urandom_range(0, 1));
        cs_bus_write = 1'($urandom_range(0, 1));
        cs_mem_width = 2'($urandom_range(0, 3));
        addr         = $urandom;
        wdata        = $urandom;
        @(posedge clk); #1;
        cs_bus_read  = 1'b0;
        cs_bus_write = 1'b0;
    endtask

    task automatic mid_reset();
        reset = 1'b1;
        #1;
        check("rst_bus_req", 32'(bus_req), 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_be", 32'(bus_be), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        exp_q.delete();
        bus_q.delete();
        last_rdata = 32'h0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Bus and completion monitor.
    initial begin
        int   stall_cnt;
        bit   in_req;
        bus_t cur;
        exp_t e;
        stall_cnt = 0;
        in_req    = 1'b0;
        cur       = '{1'b0, 32'h0, 32'h0, 4'h0};
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_cnt = 0;
                in_req    = 1'b0;
            end else begin
                if (stall) stall_cnt++;
                if (bus_req) begin
                    if (!in_req) begin
                        if (bus_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_bus_req: got 1 want 0 at %0t", $time);
                        end else begin
                            cur = bus_q.pop_front();
                        end
                        in_req = 1'b1;
                    end
                    check("bus_we", 32'(bus_we), 32'(cur.we));
                    check("bus_addr", bus_addr, cur.addr);
                    check("bus_wdata", bus_wdata, cur.wdata);
                    check("bus_be", 32'(bus_be), 32'(cur.be));
                end else begin
                    in_req = 1'b0;
                end
                if (done) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_done: got 1 want 0 at %0t", $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("rdata", rdata, e.rdata);
                        check("fault", 32'(fault), 32'(e.fault));
                        if (e.stall >= 0) check("stall_cycles", stall_cnt, e.stall);
                    end
                    stall_cnt = 0;
                end else begin
                    check("fault_without_done", 32'(fault), 32'h0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b0;
        cs_bus_read    = 1'b0;
        cs_bus_write   = 1'b0;
        cs_mem_width   = 2'b00;
        cs_load_signed = 1'b0;
        addr           = 32'h0;
        wdata          = 32'h0;
        bus_rdata      = 32'h0;
        bus_ack        = 1'b0;
        #1 reset = 1'b1;
        #2;
        check("init_bus_req", 32'(bus_req), 32'h0);
        check("init_stall", 32'(stall), 32'h0);
        check("init_done", 32'(done), 32'h0);
        check("init_fault", 32'(fault), 32'h0);
        check("init_rdata", rdata, 32'h0);
        check("init_bus_we", 32'(bus_we), 32'h0);
        check("init_bus_wdata", bus_wdata, 32'h0);
        check("init_bus_be", 32'(bus_be), 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // LW with ack in the first REQ cycle.
        access(1, 0, 2'b00, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
        check("lw_rdata", rdata, 32'hDEAD_BEEF);
        // LB / LBU from the top byte lane.
        access(1, 0, 2'b10, 1, 32'h103, 32'h0, 32'h8000_0000, 1);
        check("lb_rdata", rdata, 32'hFFFF_FF80);
        access(1, 0, 2'b10, 0, 32'h103, 32'h0, 32'h8000_0000, 0);
        check("lbu_rdata", rdata, 32'h0000_0080);
        // SH to the upper half with three wait cycles; rdata keeps the LBU result.
        access(0, 1, 2'b01, 0, 32'h102, 32'h1234_ABCD, 32'h0, 3);
        check("sh_rdata_kept", rdata, 32'h0000_0080);
        // Misaligned LW skips the bus.
        access(1, 0, 2'b00, 0, 32'h101, 32'h0, 32'h0, 0);
        check("misaligned_rdata", rdata, 32'h0);

        // Access with no ack.
        begin
            bus_t b;
            bus_ack      = 1'b0;
            cs_bus_read  = 1'b1;
            cs_mem_width = 2'b00;
            addr         = 32'h300;
            wdata        = 32'h0;
            b.we = 1'b0; b.addr = 32'h300; b.wdata = 32'h0; b.be = 4'hF;
            bus_q.push_back(b);
`ifdef BUS_TIMEOUT_EN
            begin
                exp_t e;
                e.rdata = 32'h0; e.fault = 1'b1; e.stall = 5;
                exp_q.push_back(e);
                last_rdata = 32'h0;
            end
`endif
            @(posedge clk); #1;
            cs_bus_read = 1'b0;
            for (int i = 0; i < 4; i++) begin
                check("noack_req_high", 32'(bus_req), 32'h1);
                @(posedge clk); #1;
            end
`ifdef BUS_TIMEOUT_EN
            check("tmo_req_dropped", 32'(bus_req), 32'h0);
            @(posedge clk); #1;
`else
            for (int i = 0; i < 6; i++) begin
                check("noack_req_held", 32'(bus_req), 32'h1);
                @(posedge clk); #1;
            end
            mid_reset();
`endif
        end

        // Reset in the middle of a REQ, then a normal LW.
        begin
            bus_t b;
            bus_ack      = 1'b0;
            cs_bus_read  = 1'b1;
            cs_mem_width = 2'b00;
            addr         = 32'h200;
            wdata        = 32'h55AA_1234;
            b.we = 1'b0; b.addr = 32'h200; b.wdata = 32'h55AA_1234; b.be = 4'hF;
            bus_q.push_back(b);
            @(posedge clk); #1;
            cs_bus_read = 1'b0;
            @(posedge clk); #1;
            mid_reset();
            access(1, 0, 2'b00, 0, 32'h104, 32'h0, 32'h0BAD_F00D, 1);
            check("post_reset_lw", rdata, 32'h0BAD_F00D);
        end

        // Random traffic, including both-request and misaligned cases and width 2'b11.
        for (int n = 0; n < 250; n++) begin
            int  kind;
            bit  rd;
            bit  wr;
            kind = $urandom_range(0, 19);
            rd   = (kind == 0) || (kind < 10);
            wr   = (kind == 0) || (kind >= 10);
            access(rd, wr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
                   $urandom, $urandom, $urandom_range(0, 3));
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                bus_ack   = 1'($urandom_range(0, 1));
                bus_rdata = $urandom;
                @(posedge clk); #1;
            end
        end

        bus_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("exp_queue_drained", exp_q.size(), 32'h0);
        check("bus_queue_drained", bus_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
